varredura_tabela: RTL and testbench

Sequential sweep controller for the 3-input truth-table function. It walks the input vector through every combination in ascending order and holds each one for a fixed number of cycles. On the last cycle of each hold window it samples the function output into a truth-table word. At the end it flags any mismatch against an expected word captured at start. It drives the function's `a,b,c` inputs directly and consumes its `s` output, so it sits both upstream and downstream of it.

---
 rtl/varredura_pkg.sv | 15 +
 rtl/temporizador_hold.sv | 31 +++
 rtl/varredura_tabela.sv | 98 +++++++++
 tb/tb_varredura_tabela.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/varredura_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Holds the state enum, hold-counter width and default parameters.
package varredura_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } estado_t;

  localparam int HOLD_W   = 4;
  localparam int N_DEF    = 3;
  localparam int HOLD_DEF = 1;

endpackage

// File: rtl/temporizador_hold.sv
// Hold-window counter: counts cycles spent on one input combination.
// Ports: clk, reset (async, high), clear, en; fim = last cycle of window.
module temporizador_hold
  import varredura_pkg::*;
#(
  parameter int HOLD = HOLD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic fim
);

  localparam logic [HOLD_W-1:0] LIM = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] count;

  assign fim = (count == LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= fim ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/varredura_tabela.sv
// Sweeps abc through all 2^N combinations, samples s_in into result
// and flags result != expected. Ports: clk, reset, start, expected,
// abc, s_in, busy, done, result, mismatch.
module varredura_tabela
  import varredura_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2**N-1:0] expected,
  output logic [N-1:0]    abc,
  input  logic            s_in,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] result,
  output logic            mismatch
);

  localparam int W = 2**N;

  estado_t        state;
  logic [W-1:0]   exp_q;
  logic [W-1:0]   result_next;
  logic           fim;
  logic           accept;
  logic           run;
  logic           last;

  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);
  assign last   = (abc == {N{1'b1}});

  // Result including the bit written on the current sample edge, so
  // the final compare sees the complete table.
  always_comb begin
    result_next      = result;
    result_next[abc] = s_in;
  end

  temporizador_hold #(
    .HOLD (HOLD)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (run),
    .fim   (fim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      abc      <= '0;
      result   <= '0;
      mismatch <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      exp_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            abc      <= '0;
            result   <= '0;
            mismatch <= 1'b0;
            exp_q    <= expected;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (fim) begin
            result <= result_next;
            if (last) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              mismatch <= (result_next != exp_q);
            end else begin
              abc <= abc + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_varredura_tabela.sv
// Bench for varredura_tabela: HOLD=1 and HOLD=3 instances driven by a
// truth-table function, checked against a table-level reference model.
module tb_varredura_tabela;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s;
  logic       sel;
  logic [7:0] exp_s;
  logic [7:0] fn_tt;

  logic [2:0] abc0, abc1;
  logic       s0, s1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic       mm0, mm1;
  logic [7:0] res0, res1;
  logic       st0, st1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Function under test: s = tt[abc], tt = 0xD2 by default
  assign s0  = fn_tt[abc0];
  assign s1  = fn_tt[abc1];
  assign st0 = start_s & ~sel;
  assign st1 = start_s & sel;

  varredura_tabela #(.N(3), .HOLD(1)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .start    (st0),
    .expected (exp_s),
    .abc      (abc0),
    .s_in     (s0),
    .busy     (busy0),
    .done     (done0),
    .result   (res0),
    .mismatch (mm0)
  );

  varredura_tabela #(.N(3), .HOLD(3)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .start    (st1),
    .expected (exp_s),
    .abc      (abc1),
    .s_in     (s1),
    .busy     (busy1),
    .done     (done1),
    .result   (res1),
    .mismatch (mm1)
  );

  logic [2:0] abc_o;
  logic       busy_o, done_o, mm_o;
  logic [7:0] res_o;

  assign abc_o  = sel ? abc1  : abc0;
  assign busy_o = sel ? busy1 : busy0;
  assign done_o = sel ? done1 : done0;
  assign mm_o   = sel ? mm1   : mm0;
  assign res_o  = sel ? res1  : res0;

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if ((busy0 && done0) || (busy1 && done1)) begin
        n_bad++;
        $display("FAIL busy_done_overlap: b0=%b d0=%b b1=%b d1=%b, required not both high",
                 busy0, done0, busy1, done1);
      end
    end
  end

  task automatic sweep(input logic [7:0] e, input int hold);
    int total;
    logic exp_mm;
    total  = 8 * hold;
    exp_mm = (fn_tt != e);
    @(negedge clk);
    exp_s   = e;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    exp_s   = ~e;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || abc_o !== 3'(c / hold)) begin
        n_bad++;
        $display("FAIL sweep_run c=%0d h=%0d: busy=%b done=%b abc=%0d, required 1 0 %0d",
                 c, hold, busy_o, done_o, abc_o, c / hold);
      end
      if (c == 0) begin
        n_cmp++;
        if (res_o !== 8'h00 || mm_o !== 1'b0) begin
          n_bad++;
          $display("FAIL sweep_clear: result=%02h mismatch=%b, required 00 0",
                   res_o, mm_o);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || res_o !== fn_tt ||
        mm_o !== exp_mm || abc_o !== 3'd7) begin
      n_bad++;
      $display("FAIL sweep_done h=%0d: done=%b busy=%b result=%02h mm=%b abc=%0d, required 1 0 %02h %b 7",
               hold, done_o, busy_o, res_o, mm_o, abc_o, fn_tt, exp_mm);
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || res_o !== fn_tt ||
        mm_o !== exp_mm || abc_o !== 3'd7) begin
      n_bad++;
      $display("FAIL sweep_idle h=%0d: done=%b busy=%b result=%02h mm=%b abc=%0d, required 0 0 %02h %b 7",
               hold, done_o, busy_o, res_o, mm_o, abc_o, fn_tt, exp_mm);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_s = 1'b0;
    sel     = 1'b0;
    exp_s   = 8'h00;
    fn_tt   = 8'hD2;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (abc0 !== 3'd0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        res0 !== 8'h00 || mm0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_h1: abc=%0d busy=%b done=%b result=%02h mm=%b, required 0 0 0 00 0",
               abc0, busy0, done0, res0, mm0);
    end
    n_cmp++;
    if (abc1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
        res1 !== 8'h00 || mm1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_h3: abc=%0d busy=%b done=%b result=%02h mm=%b, required 0 0 0 00 0",
               abc1, busy1, done1, res1, mm1);
    end
  endtask

  task automatic test_basic();
    fn_tt = 8'hD2;
    sel   = 1'b0;
    sweep(8'hD2, 1);
  endtask

  task automatic test_mismatch();
    fn_tt = 8'hD2;
    sel   = 1'b0;
    sweep(8'hD3, 1);
    sweep(8'hD2, 1);
  endtask

  task automatic test_hold3();
    fn_tt = 8'hD2;
    sel   = 1'b1;
    sweep(8'hD2, 3);
    sel   = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p;
    fn_tt = 8'hD2;
    sel   = 1'b0;
    @(negedge clk);
    exp_s   = 8'hD2;
    start_s = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) @(negedge clk);
      p = c % 10;
      n_cmp++;
      if (p < 8) begin
        if (busy0 !== 1'b1 || done0 !== 1'b0 || abc0 !== 3'(p)) begin
          n_bad++;
          $display("FAIL b2b_run c=%0d: busy=%b done=%b abc=%0d, required 1 0 %0d",
                   c, busy0, done0, abc0, p);
        end
      end else if (p == 8) begin
        if (busy0 !== 1'b0 || done0 !== 1'b1 || res0 !== fn_tt || mm0 !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_done c=%0d: busy=%b done=%b result=%02h mm=%b, required 0 1 %02h 0",
                   c, busy0, done0, res0, mm0, fn_tt);
        end
      end else begin
        if (busy0 !== 1'b0 || done0 !== 1'b0 || abc0 !== 3'd7) begin
          n_bad++;
          $display("FAIL b2b_idle c=%0d: busy=%b done=%b abc=%0d, required 0 0 7",
                   c, busy0, done0, abc0);
        end
      end
    end
    start_s = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_stop: busy=%b done=%b, required 0 0", busy0, done0);
      end
    end
  endtask

  task automatic test_reset_mid();
    fn_tt = 8'hD2;
    sel   = 1'b0;
    @(negedge clk);
    exp_s   = 8'hD2;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (abc0 !== 3'd4 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pre: abc=%0d busy=%b, required 4 1", abc0, busy0);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (abc0 !== 3'd0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        res0 !== 8'h00 || mm0 !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_async: abc=%0d busy=%b done=%b result=%02h mm=%b, required 0 0 0 00 0",
               abc0, busy0, done0, res0, mm0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || abc0 !== 3'd0) begin
        n_bad++;
        $display("FAIL rmid_quiet c=%0d: done=%b busy=%b abc=%0d, required 0 0 0",
                 c, done0, busy0, abc0);
      end
    end
    sweep(8'hD2, 1);
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      fn_tt = 8'($urandom);
      e     = ($urandom_range(0, 1) == 1) ? fn_tt : 8'($urandom);
      sel   = ($urandom_range(0, 1) == 1);
      sweep(e, sel ? 3 : 1);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_hold3();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
